// File: rtl/gray_cnt_sync_mc.sv
// Multi-channel gray-code counter synchronizer: per-channel sync chain, gray->binary
// conversion, change strobe and modular delta. Define GRAY_CNT_SYNC_ERR_CHK_EN for the sticky multi-bit-change check.

module gray_cnt_sync_ch #(
  parameter int WIDTH  = 28,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             clr_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] cnt_bin_o,
  output logic             cnt_vld_o,
  output logic [WIDTH-1:0] cnt_delta_o,
  output logic             err_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             g_p_q;
  logic [WIDTH-1:0]             g_s;
  logic                         chg;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] cnt_bin_q, cnt_bin_d;
  logic [WIDTH-1:0] cnt_delta_q, cnt_delta_d;
  logic             cnt_vld_q, cnt_vld_d;

  assign g_s = sync_q[STAGES-1];
  assign chg = (g_s != g_p_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      g_p_q  <= '0;
    end else begin
      sync_q[0] <= gray_i;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      g_p_q <= g_s;
    end
  end

  // bin[j] is the XOR of all gray bits at and above j
  always_comb begin
    bin_d = '0;
    for (int j = 0; j < WIDTH; j++) bin_d[j] = ^(g_s >> j);
  end

  always_comb begin
    cnt_bin_d   = bin_d;
    cnt_vld_d   = 1'b0;
    cnt_delta_d = '0;
    if (!clr_i && chg) begin
      cnt_vld_d   = 1'b1;
      cnt_delta_d = bin_d - cnt_bin_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_bin_q   <= '0;
      cnt_vld_q   <= 1'b0;
      cnt_delta_q <= '0;
    end else begin
      cnt_bin_q   <= cnt_bin_d;
      cnt_vld_q   <= cnt_vld_d;
      cnt_delta_q <= cnt_delta_d;
    end
  end

  assign cnt_bin_o   = cnt_bin_q;
  assign cnt_vld_o   = cnt_vld_q;
  assign cnt_delta_o = cnt_delta_q;

`ifdef GRAY_CNT_SYNC_ERR_CHK_EN
  logic [WIDTH-1:0] diff;
  logic             multi;
  logic             err_q, err_d;

  // more than one set bit: clearing the lowest one still leaves something
  assign diff  = g_s ^ g_p_q;
  assign multi = |(diff & (diff - WIDTH'(1)));

  always_comb begin
    err_d = err_q;
    if (err_clr_i)          err_d = 1'b0;
    if (!clr_i && multi)    err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = 1'b0;
`endif

endmodule

module gray_cnt_sync_mc #(
  parameter int WIDTH    = 28,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] gray_in,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       err_clr,
  output logic [CHANNELS*WIDTH-1:0] cnt_bin,
  output logic [CHANNELS-1:0]       cnt_vld,
  output logic [CHANNELS*WIDTH-1:0] cnt_delta,
  output logic [CHANNELS-1:0]       err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    gray_cnt_sync_ch #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
    ) u_ch (
      .clk         (clk),
      .resetn      (resetn),
      .gray_i      (gray_in[i*WIDTH +: WIDTH]),
      .clr_i       (clr[i]),
      .err_clr_i   (err_clr[i]),
      .cnt_bin_o   (cnt_bin[i*WIDTH +: WIDTH]),
      .cnt_vld_o   (cnt_vld[i]),
      .cnt_delta_o (cnt_delta[i*WIDTH +: WIDTH]),
      .err_o       (err[i])
    );
  end

endmodule

// File: tb/tb_gray_cnt_sync_mc.sv
// Table-driven bench for gray_cnt_sync_mc (WIDTH=4, CHANNELS=2, STAGES=3) with a due-cycle scoreboard.

module tb_gray_cnt_sync_mc;
  localparam int W = 4, C = 2, S = 3;
`ifdef GRAY_CNT_SYNC_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetn;
  logic [C*W-1:0] gray_in;
  logic [C-1:0]   clr, err_clr;
  logic [C*W-1:0] cnt_bin, cnt_delta;
  logic [C-1:0]   cnt_vld, err;

  gray_cnt_sync_mc #(.WIDTH(W), .CHANNELS(C), .STAGES(S)) dut (
    .clk(clk), .resetn(resetn), .gray_in(gray_in), .clr(clr), .err_clr(err_clr),
    .cnt_bin(cnt_bin), .cnt_vld(cnt_vld), .cnt_delta(cnt_delta), .err(err)
  );

  always #5 clk = ~clk;

  // row: gray per channel, clr/err_clr aligned to when that gray reaches the output stage, expected outputs
  typedef struct {
    logic [3:0] g0, g1;
    logic [1:0] clr, eclr;
    logic [3:0] b0, b1;
    logic [1:0] vld;
    logic [3:0] d0, d1;
    logic [1:0] err;
  } vec_t;

  typedef struct { int due; int idx; vec_t v; } exp_t;

  localparam int N = 16;
  vec_t tbl [N];
  exp_t q [$];
  int   total = 0, bad = 0, cyc = 0;

  function automatic vec_t mk(logic [3:0] g0, logic [3:0] g1, logic [1:0] c, logic [1:0] ec,
                              logic [3:0] b0, logic [3:0] b1, logic [1:0] v,
                              logic [3:0] d0, logic [3:0] d1, logic [1:0] e);
    vec_t r;
    r.g0 = g0; r.g1 = g1; r.clr = c; r.eclr = ec;
    r.b0 = b0; r.b1 = b1; r.vld = v; r.d0 = d0; r.d1 = d1; r.err = e;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h exp=%0h", name, idx, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string name, input int idx);
    check({name, "_bin"}, idx, 32'(cnt_bin), 32'd0);
    check({name, "_vld"}, idx, 32'(cnt_vld), 32'd0);
    check({name, "_dlt"}, idx, 32'(cnt_delta), 32'd0);
    check({name, "_err"}, idx, 32'(err), 32'd0);
  endtask

  // advance one clock, then compare every scoreboard entry due now
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("bin", e.idx, 32'(cnt_bin), 32'({e.v.b1, e.v.b0}));
      check("vld", e.idx, 32'(cnt_vld), 32'(e.v.vld));
      check("dlt", e.idx, 32'(cnt_delta), 32'({e.v.d1, e.v.d0}));
      check("err", e.idx, 32'(err), 32'(e.v.err & {2{ERR_EN}}));
    end
  endtask

  initial begin
    //            g0    g1    clr    eclr   b0     b1    vld    d0    d1    err
    tbl[0]  = mk(4'h1, 4'h0, 2'b00, 2'b00, 4'd1,  4'd0, 2'b01, 4'd1, 4'd0, 2'b00);
    tbl[1]  = mk(4'h1, 4'h0, 2'b00, 2'b00, 4'd1,  4'd0, 2'b00, 4'd0, 4'd0, 2'b00);
    tbl[2]  = mk(4'h3, 4'h1, 2'b00, 2'b00, 4'd2,  4'd1, 2'b11, 4'd1, 4'd1, 2'b00);
    tbl[3]  = mk(4'h2, 4'h3, 2'b00, 2'b00, 4'd3,  4'd2, 2'b11, 4'd1, 4'd1, 2'b00);
    tbl[4]  = mk(4'h8, 4'h3, 2'b01, 2'b00, 4'd15, 4'd2, 2'b00, 4'd0, 4'd0, 2'b00);
    tbl[5]  = mk(4'h0, 4'h3, 2'b00, 2'b00, 4'd0,  4'd2, 2'b01, 4'd1, 4'd0, 2'b00);
    tbl[6]  = mk(4'h0, 4'h3, 2'b00, 2'b00, 4'd0,  4'd2, 2'b00, 4'd0, 4'd0, 2'b00);
    tbl[7]  = mk(4'h0, 4'h0, 2'b10, 2'b00, 4'd0,  4'd0, 2'b00, 4'd0, 4'd0, 2'b00);
    tbl[8]  = mk(4'h0, 4'h3, 2'b00, 2'b00, 4'd0,  4'd2, 2'b10, 4'd0, 4'd2, 2'b10);
    tbl[9]  = mk(4'h0, 4'h3, 2'b00, 2'b00, 4'd0,  4'd2, 2'b00, 4'd0, 4'd0, 2'b10);
    tbl[10] = mk(4'h0, 4'h3, 2'b00, 2'b10, 4'd0,  4'd2, 2'b00, 4'd0, 4'd0, 2'b00);
    tbl[11] = mk(4'h0, 4'h0, 2'b10, 2'b00, 4'd0,  4'd0, 2'b00, 4'd0, 4'd0, 2'b00);
    tbl[12] = mk(4'h0, 4'h3, 2'b00, 2'b10, 4'd0,  4'd2, 2'b10, 4'd0, 4'd2, 2'b10);
    tbl[13] = mk(4'h0, 4'h3, 2'b00, 2'b00, 4'd0,  4'd2, 2'b00, 4'd0, 4'd0, 2'b10);
    tbl[14] = mk(4'h1, 4'h3, 2'b01, 2'b00, 4'd1,  4'd2, 2'b00, 4'd0, 4'd0, 2'b10);
    tbl[15] = mk(4'h3, 4'h3, 2'b01, 2'b00, 4'd2,  4'd2, 2'b00, 4'd0, 4'd0, 2'b10);

    resetn = 1'b0; gray_in = '0; clr = '0; err_clr = '0;
    for (int i = 0; i < 3; i++) step();
    check_zero("rst", 0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_zero("idle", i);
    end

    // gray for row n enters now; its clr/err_clr must arrive S cycles later
    for (int n = 0; n < N + S + 1; n++) begin
      if (n < N) begin
        gray_in = {tbl[n].g1, tbl[n].g0};
        q.push_back('{due: cyc + S + 1, idx: n, v: tbl[n]});
      end
      if (n >= S && n - S < N) begin
        clr     = tbl[n-S].clr;
        err_clr = tbl[n-S].eclr;
      end else begin
        clr = '0; err_clr = '0;
      end
      step();
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    check("sb_drain", 0, 32'(q.size()), 32'd0);

    // reset one cycle after a gray change: pipeline dropped, no late pulse
    gray_in = {4'h3, 4'h7};
    step();
    resetn = 1'b0; gray_in = '0;
    #1;
    check_zero("async_rst", 0);
    step();
    check_zero("in_rst", 0);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_zero("post_rst", i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end
endmodule
